bullet_plotter: RTL and testbench
=================================

// Module: bullet_plotter
// PURPOSE
//  Downstream of the shot controller: consumes bullet position/colour + draw strobe, emits one
//  pixel per cycle to the VGA adapter (x, y, colour, plot). Per request it erases the previously
//  drawn bullet sprite with background colour, then draws the new sprite. Stale pixels are never left.
//  Sits between shot logic and the shared VGA adapter port.
// PARAMETERS
//  SPRITE_W   1       sprite width in pixels (1..4)
//  SPRITE_H   4       sprite height in pixels (1..8)
//  SCREEN_W   160     visible columns; pixels with x >= SCREEN_W are clipped
//  SCREEN_H   120     visible rows; pixels with y >= SCREEN_H are clipped
//  BG_COLOUR  3'b000  erase colour
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  reset       in   1  asynchronous, active-low reset
//  draw_req    in   1  request strobe (shot drawEn); sampled every cycle
//  bullet_x    in   8  new sprite top-left x, sampled with draw_req
//  bullet_y    in   7  new sprite top-left y, sampled with draw_req
//  colour      in   3  new sprite colour; 3'b000 = erase only, no redraw
//  vga_x       out  8  pixel x to VGA adapter
//  vga_y       out  7  pixel y to VGA adapter
//  vga_colour  out  3  pixel colour
//  vga_plot    out  1  write enable for current pixel
//  busy        out  1  high in every state except IDLE
//  done        out  1  one-cycle pulse when a request finishes
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; vga_x/vga_y/vga_colour/vga_plot=0; busy=0; done=0;
//   old_valid=0; pending=0; old_x/old_y=0. Screen contents not cleared (upstream's job).
//  Request capture: draw_req=1 in any cycle latches {bullet_x,bullet_y,colour} into pending
//   slot (one deep). Newer request overwrites an unserved one. Requests are never back-pressured.
//  States: IDLE, ERASE, DRAW, DONE. Outputs registered; one pixel per cycle in ERASE/DRAW.
//   IDLE : if pending (or draw_req this cycle), consume it -> cur = pending data, pending cleared.
//          -> ERASE if old_valid; else -> DRAW if colour!=0; else -> DONE.
//   ERASE: scan W*H pixels at old_x+dx, old_y+dy, vga_colour=BG_COLOUR.
//          After last pixel: -> DRAW if cur colour!=0, else -> DONE.
//   DRAW : scan W*H pixels at cur_x+dx, cur_y+dy, vga_colour=cur colour.
//          After last pixel: old_x/old_y <= cur, old_valid <= 1; -> DONE.
//   DONE : done=1, vga_plot=0 for one cycle; if erase-only request, old_valid <= 0. -> IDLE.
//  Scan order: dx fastest, dy slowest; dx,dy start at 0 on each ERASE/DRAW entry.
//  Latency: request seen in IDLE at cycle 0 -> first pixel on outputs cycle 1;
//   total = (old_valid ? W*H : 0) + (colour!=0 ? W*H : 0) cycles, then done pulse, IDLE next.
//  Clipping: sum computed one bit wider (9b x, 8b y); if x>=SCREEN_W or y>=SCREEN_H, pixel slot
//   still consumes its cycle but vga_plot=0. Timing is data-independent.
//  Outside ERASE/DRAW vga_plot=0; vga_x/vga_y/vga_colour hold last values.
//  Request arriving while busy is held in pending and served from IDLE after DONE (IDLE stays 1 cycle).
//  Simultaneous draw_req and consume in IDLE: the incoming request is the one served.
//  Reset mid-operation: immediate return to reset values; partially drawn sprite left on screen.
// STRUCTURE
//  Shared package (game_pkg): SCREEN_W, SCREEN_H, colour constants (BLACK, WHITE), VGA coord widths.
//  Sub-module sprite_scan_ctr: dx/dy counter with start, enable, last flag; parameterised W,H.
//  Top: FSM, pending slot, old/cur position registers, clip compare, output registers.
// TESTING  (W=1, H=4 unless noted)
//  1 After reset, req (80,100,111) -> vga_plot=1 at (80,100..103) col 111 cycles 1-4; done cycle 5; busy 0 cycle 6.
//  2 Then req (80,95,111) -> erase (80,100..103) col 000 for 4 cycles, draw (80,95..98) col 111 for 4, done.
//  3 Req (159,118,111) from empty -> plot at (159,118),(159,119); y=120,121 slots plot=0; still 4 cycles, done.
//  4 While busy, issue req A (10,10) then req B (20,20) -> after current done, only B served; A never plotted.
//  5 Req (x,y,000) with old sprite at (80,95) -> 4 erase pixels only, done, old_valid=0; next req has no erase phase.
//  6 Assert reset during ERASE cycle 2 -> outputs zero asynchronously, busy=0; next req draws with no erase phase.

Source files
------------

// File: rtl/game_pkg.sv
// Shared screen geometry, colour constants and plotter types for the bullet path.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package game_pkg;

  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int COL_W   = 3;
  localparam int CNT_W   = 3;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [COL_W-1:0] BLACK = 3'b000;
  localparam logic [COL_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_DRAW,
    ST_DONE
  } plot_state_t;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
  } bullet_t;

endpackage

// File: rtl/sprite_scan_ctr.sv
// Sprite pixel scanner: dx runs fastest, dy slowest, restarted at (0,0) by start.
// Latency: next_dx/next_dy show this cycle's successor; the count updates on the next edge.
// Backpressure: none; advances only while enable is high.
module sprite_scan_ctr
  import game_pkg::*;
#(
  parameter int W = 1,
  parameter int H = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  output logic [CNT_W-1:0] next_dx,
  output logic [CNT_W-1:0] next_dy,
  output logic             last
);

  logic [CNT_W-1:0] dx;
  logic [CNT_W-1:0] dy;

  assign last = (dx == CNT_W'(W - 1)) && (dy == CNT_W'(H - 1));

  // Successor position: start wins, otherwise step dx and carry into dy at the row end.
  always_comb begin
    next_dx = dx;
    next_dy = dy;
    if (start) begin
      next_dx = '0;
      next_dy = '0;
    end else if (enable) begin
      if (dx == CNT_W'(W - 1)) begin
        next_dx = '0;
        next_dy = dy + CNT_W'(1);
      end else begin
        next_dx = dx + CNT_W'(1);
      end
    end
  end

  // Hold the position currently being emitted by the plotter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dx <= '0;
      dy <= '0;
    end else begin
      dx <= next_dx;
      dy <= next_dy;
    end
  end

endmodule

// File: rtl/bullet_plotter.sv
// Bullet plotter: erases the previous sprite in background colour, then draws the new one.
// Latency: first pixel one cycle after the request is taken in IDLE; one pixel per cycle.
// Backpressure: none; a one-deep pending slot keeps only the newest unserved request.
module bullet_plotter #(
  parameter int          SPRITE_W  = 1,
  parameter int          SPRITE_H  = 4,
  parameter int          SCREEN_W  = game_pkg::SCREEN_W,
  parameter int          SCREEN_H  = game_pkg::SCREEN_H,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw_req,
  input  logic [7:0] bullet_x,
  input  logic [6:0] bullet_y,
  input  logic [2:0] colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  import game_pkg::*;

  plot_state_t state;

  bullet_t     pend;
  logic        pend_vld;
  bullet_t     cur;
  logic [7:0]  old_x;
  logic [6:0]  old_y;
  logic        old_valid;

  bullet_t     incoming;
  bullet_t     take_dat;
  logic        take;

  logic        scan_start;
  logic        scan_en;
  logic        scan_last;
  logic [CNT_W-1:0] next_dx;
  logic [CNT_W-1:0] next_dy;

  logic        emit;
  logic [7:0]  emit_x;
  logic [6:0]  emit_y;
  logic [2:0]  emit_col;
  logic [8:0]  sum_x;
  logic [7:0]  sum_y;
  logic        on_screen;

  assign incoming = '{x: bullet_x, y: bullet_y, colour: colour};
  // A request arriving in the same cycle as the consume replaces the pending one.
  assign take_dat = draw_req ? incoming : pend;
  assign take     = (state == ST_IDLE) && (draw_req || pend_vld);

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  sprite_scan_ctr #(
    .W (SPRITE_W),
    .H (SPRITE_H)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .start   (scan_start),
    .enable  (scan_en),
    .next_dx (next_dx),
    .next_dy (next_dy),
    .last    (scan_last)
  );

  // Pick the pixel to register next: which sprite, which colour, and how the scanner moves.
  always_comb begin
    scan_start = 1'b0;
    scan_en    = 1'b0;
    emit       = 1'b0;
    emit_x     = old_x;
    emit_y     = old_y;
    emit_col   = BG_COLOUR;
    case (state)
      ST_IDLE: begin
        if (take) begin
          scan_start = 1'b1;
          if (old_valid) begin
            emit = 1'b1;
          end else if (take_dat.colour != BLACK) begin
            emit     = 1'b1;
            emit_x   = take_dat.x;
            emit_y   = take_dat.y;
            emit_col = take_dat.colour;
          end
        end
      end
      ST_ERASE: begin
        if (scan_last) begin
          if (cur.colour != BLACK) begin
            scan_start = 1'b1;
            emit       = 1'b1;
            emit_x     = cur.x;
            emit_y     = cur.y;
            emit_col   = cur.colour;
          end
        end else begin
          scan_en = 1'b1;
          emit    = 1'b1;
        end
      end
      ST_DRAW: begin
        if (!scan_last) begin
          scan_en  = 1'b1;
          emit     = 1'b1;
          emit_x   = cur.x;
          emit_y   = cur.y;
          emit_col = cur.colour;
        end
      end
      default: ;
    endcase
  end

  // Sums are one bit wider so sprites hanging off the right/bottom edge clip instead of wrapping.
  assign sum_x     = {1'b0, emit_x} + {6'd0, next_dx};
  assign sum_y     = {1'b0, emit_y} + {5'd0, next_dy};
  assign on_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));

  // Control FSM with pending slot, sprite position history and registered pixel outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pend       <= '0;
      pend_vld   <= 1'b0;
      cur        <= '0;
      old_x      <= '0;
      old_y      <= '0;
      old_valid  <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      if (take) begin
        pend_vld <= 1'b0;
      end else if (draw_req) begin
        pend_vld <= 1'b1;
        pend     <= incoming;
      end

      if (emit) begin
        vga_x      <= sum_x[7:0];
        vga_y      <= sum_y[6:0];
        vga_colour <= emit_col;
        vga_plot   <= on_screen;
      end else begin
        vga_plot   <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (take) begin
            cur <= take_dat;
            if (old_valid)                     state <= ST_ERASE;
            else if (take_dat.colour != BLACK) state <= ST_DRAW;
            else                               state <= ST_DONE;
          end
        end
        ST_ERASE: begin
          if (scan_last) state <= (cur.colour != BLACK) ? ST_DRAW : ST_DONE;
        end
        ST_DRAW: begin
          if (scan_last) begin
            old_x     <= cur.x;
            old_y     <= cur.y;
            old_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (cur.colour == BLACK) old_valid <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_plotter.sv
// Bench for bullet_plotter: directed scenarios then randomized requests against a sprite model.
// Latency: checks each output cycle one time unit after the rising edge.
// Backpressure: injects overlapping requests to exercise the pending slot.
module tb_bullet_plotter;

  localparam int SW = 1;
  localparam int SH = 4;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  logic       clk = 1'b0;
  logic       reset;
  logic       draw_req;
  logic [7:0] bullet_x;
  logic [6:0] bullet_y;
  logic [2:0] colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Reference state: where the last drawn sprite sits on screen, if any.
  int m_old_valid = 0;
  int m_old_x     = 0;
  int m_old_y     = 0;

  typedef struct {
    int x;
    int y;
    int col;
    int plot;
  } pix_t;

  bullet_plotter #(
    .SPRITE_W  (SW),
    .SPRITE_H  (SH),
    .SCREEN_W  (SCR_W),
    .SCREEN_H  (SCR_H),
    .BG_COLOUR (3'b000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .draw_req   (draw_req),
    .bullet_x   (bullet_x),
    .bullet_y   (bullet_y),
    .colour     (colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int x, input int y, input int c);
    draw_req = v;
    bullet_x = 8'(x);
    bullet_y = 7'(y);
    colour   = 3'(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one request from IDLE to the following IDLE cycle, checking every output cycle.
  // Optional requests A (slot 0) and B (slot 1) are injected while the plotter is busy.
  task automatic expect_req(input bit from_pend, input int x, input int y, input int c,
                            input bit inj_a, input int ax, input int ay, input int ac,
                            input bit inj_b, input int bx, input int by, input int bc);
    pix_t q[$];
    pix_t p;
    if (m_old_valid != 0) begin
      for (int dy = 0; dy < SH; dy++)
        for (int dx = 0; dx < SW; dx++) begin
          p.x = m_old_x + dx; p.y = m_old_y + dy; p.col = 0;
          p.plot = (p.x < SCR_W && p.y < SCR_H) ? 1 : 0;
          q.push_back(p);
        end
    end
    if (c != 0) begin
      for (int dy = 0; dy < SH; dy++)
        for (int dx = 0; dx < SW; dx++) begin
          p.x = x + dx; p.y = y + dy; p.col = c;
          p.plot = (p.x < SCR_W && p.y < SCR_H) ? 1 : 0;
          q.push_back(p);
        end
    end
    chk("idle_busy", 32'(busy), 0);
    if (!from_pend) drive(1, x, y, c);
    step();
    for (int k = 0; k <= q.size(); k++) begin
      drive(0, 0, 0, 0);
      if (k == 0 && inj_a) drive(1, ax, ay, ac);
      else if (k == 1 && inj_b) drive(1, bx, by, bc);
      if (k < q.size()) begin
        chk("pix_plot", 32'(vga_plot), 32'(q[k].plot));
        if (q[k].plot != 0) begin
          chk("pix_x", 32'(vga_x), 32'(q[k].x));
          chk("pix_y", 32'(vga_y), 32'(q[k].y));
          chk("pix_col", 32'(vga_colour), 32'(q[k].col));
        end
        chk("pix_done", 32'(done), 0);
        chk("pix_busy", 32'(busy), 1);
      end else begin
        chk("done_pulse", 32'(done), 1);
        chk("done_plot", 32'(vga_plot), 0);
        chk("done_busy", 32'(busy), 1);
      end
      step();
    end
    drive(0, 0, 0, 0);
    chk("after_done", 32'(done), 0);
    chk("after_busy", 32'(busy), 0);
    chk("after_plot", 32'(vga_plot), 0);
    if (c != 0) begin
      m_old_valid = 1; m_old_x = x; m_old_y = y;
    end else begin
      m_old_valid = 0;
    end
  endtask

  initial begin
    int rx, ry, rc, len, sx, sy, sc;
    bit ia, ib;
    int ax, ay, ac, bx, by, bc;

    drive(0, 0, 0, 0);
    reset = 1'b0;
    #12;
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_x", 32'(vga_x), 0);
    chk("rst_y", 32'(vga_y), 0);
    chk("rst_col", 32'(vga_colour), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b1;
    step();
    step();

    // Plain draw from an empty screen.
    expect_req(0, 80, 100, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    // Move: erase old position then draw the new one.
    expect_req(0, 80, 95, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    // Erase-only request.
    expect_req(0, 30, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Bottom-right corner with clipped rows; no erase since old sprite was removed.
    expect_req(0, 159, 118, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    // Two requests while busy: only the newer one is served afterwards.
    expect_req(0, 40, 40, 5, 1, 10, 10, 3, 1, 20, 20, 6);
    expect_req(1, 20, 20, 6, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of the erase phase.
    drive(1, 50, 50, 7);
    step();
    drive(0, 0, 0, 0);
    step();
    #1 reset = 1'b0;
    #1;
    chk("midrst_plot", 32'(vga_plot), 0);
    chk("midrst_x", 32'(vga_x), 0);
    chk("midrst_y", 32'(vga_y), 0);
    chk("midrst_col", 32'(vga_colour), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    m_old_valid = 0;
    #10 reset = 1'b1;
    step();
    step();
    expect_req(0, 60, 20, 2, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized requests, biased toward the clipping edges, with random overlap.
    for (int it = 0; it < 40; it++) begin
      rx = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
      ry = ($urandom_range(0, 3) == 0) ? $urandom_range(112, 127) : $urandom_range(0, 119);
      rc = $urandom_range(0, 7);
      len = ((m_old_valid != 0) ? SW * SH : 0) + ((rc != 0) ? SW * SH : 0);
      ia = 0; ib = 0;
      ax = $urandom_range(0, 255); ay = $urandom_range(0, 127); ac = $urandom_range(0, 7);
      bx = $urandom_range(0, 255); by = $urandom_range(0, 127); bc = $urandom_range(0, 7);
      if (len >= 2 && $urandom_range(0, 2) == 0) begin
        ia = 1'($urandom_range(0, 1));
        ib = 1'($urandom_range(0, 1));
        if (!ia && !ib) ib = 1;
      end
      expect_req(0, rx, ry, rc, ia, ax, ay, ac, ib, bx, by, bc);
      if (ia || ib) begin
        sx = ib ? bx : ax; sy = ib ? by : ay; sc = ib ? bc : ac;
        expect_req(1, sx, sy, sc, 0, 0, 0, 0, 0, 0, 0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
